// File: rtl/encrypt_pkg.sv
// Shared definitions for the LWE encryption controller: the FSM state type,
// default widths and the plaintext scaling helper.
package encrypt_pkg;

    localparam int PLAINTEXT_WIDTH_DEF  = 6;
    localparam int DIMENSION_DEF        = 1;
    localparam int CIPHERTEXT_WIDTH_DEF = 10;
    localparam int BIG_N_DEF            = 30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // Moves the plaintext into the top bits of a ciphertext word. The caller
    // passes CW-PW as the shift and truncates the result to CW bits.
    function automatic logic [31:0] plaintext_scale(input logic [31:0] pt, input int shift);
        return pt << shift;
    endfunction

endpackage

// File: rtl/encrypt_ctrl_subset_sum.sv
// Combinational masked modular sum: adds every CW-bit entry whose mask bit
// is set. Results wrap modulo 2^CW because the accumulator is CW bits wide.
module subset_sum #(
    parameter int BIG_N            = 30,
    parameter int CIPHERTEXT_WIDTH = 10
) (
    input  logic [BIG_N*CIPHERTEXT_WIDTH-1:0] data,
    input  logic [BIG_N-1:0]                  mask,
    output logic [CIPHERTEXT_WIDTH-1:0]       sum
);

    logic [CIPHERTEXT_WIDTH-1:0] acc_s;

    // Accumulate the selected entries; synthesis rebalances the chain into a tree.
    always_comb begin
        acc_s = '0;
        for (int i = 0; i < BIG_N; i++) begin
            if (mask[i]) begin
                acc_s = acc_s + data[i*CIPHERTEXT_WIDTH +: CIPHERTEXT_WIDTH];
            end else begin
                acc_s = acc_s;
            end
        end
    end

    assign sum = acc_s;

endmodule

// File: rtl/encrypt_ctrl.sv
// LWE encryption sequencer: fetches one public-key column per ciphertext
// word, reduces the noise-selected subset, adds the scaled plaintext on the
// final (b) column and streams each word out on a valid/ready interface.
module encrypt_ctrl
    import encrypt_pkg::*;
#(
    parameter int PLAINTEXT_WIDTH  = PLAINTEXT_WIDTH_DEF,
    parameter int DIMENSION        = DIMENSION_DEF,
    parameter int CIPHERTEXT_WIDTH = CIPHERTEXT_WIDTH_DEF,
    parameter int BIG_N            = BIG_N_DEF,
    parameter int COL_W            = ($clog2(DIMENSION + 1) > 1) ? $clog2(DIMENSION + 1) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_valid,
    output logic                              start_ready,
    input  logic [PLAINTEXT_WIDTH-1:0]        plaintext,
    input  logic [BIG_N-1:0]                  noise_select,
    output logic                              pk_rd_en,
    output logic [COL_W-1:0]                  pk_rd_addr,
    input  logic [BIG_N*CIPHERTEXT_WIDTH-1:0] pk_rd_data,
    output logic                              ct_valid,
    input  logic                              ct_ready,
    output logic [CIPHERTEXT_WIDTH-1:0]       ct_data,
    output logic [COL_W-1:0]                  ct_index,
    output logic                              ct_last,
    output logic                              busy
);

    localparam int               CW       = CIPHERTEXT_WIDTH;
    localparam int               PT_SHIFT = CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(DIMENSION);

    state_e                     state_r;
    state_e                     state_nxt_s;
    logic [COL_W-1:0]           col_r;
    logic [COL_W-1:0]           col_nxt_s;
    logic [PLAINTEXT_WIDTH-1:0] pt_r;
    logic [BIG_N-1:0]           noise_r;
    logic [CW-1:0]              sum_s;
    logic [CW-1:0]              pt_term_s;
    logic [CW-1:0]              word_s;
    logic                       accept_s;

    logic                       start_ready_r;
    logic                       pk_rd_en_r;
    logic [COL_W-1:0]           pk_rd_addr_r;
    logic                       ct_valid_r;
    logic [CW-1:0]              ct_data_r;
    logic [COL_W-1:0]           ct_index_r;
    logic                       ct_last_r;
    logic                       busy_r;

    subset_sum #(
        .BIG_N            (BIG_N),
        .CIPHERTEXT_WIDTH (CIPHERTEXT_WIDTH)
    ) u_subset_sum (
        .data (pk_rd_data),
        .mask (noise_r),
        .sum  (sum_s)
    );

    assign accept_s = (state_r == ST_IDLE) && start_valid;

    // Ciphertext word: subset sum, plus the scaled message on the b column.
    always_comb begin
        pt_term_s = CW'(plaintext_scale(32'(pt_r), PT_SHIFT));
        if (col_r == LAST_COL) begin
            word_s = sum_s + pt_term_s;
        end else begin
            word_s = sum_s;
        end
    end

    // Next-state and column-counter decode.
    always_comb begin
        state_nxt_s = state_r;
        col_nxt_s   = col_r;
        case (state_r)
            ST_IDLE: begin
                if (start_valid) begin
                    state_nxt_s = ST_FETCH;
                    col_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                state_nxt_s = ST_OUT;
            end
            ST_OUT: begin
                if (ct_ready) begin
                    if (col_r == LAST_COL) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_FETCH;
                        col_nxt_s   = col_r + COL_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                col_nxt_s   = '0;
            end
        endcase
    end

    // FSM state, column counter and the operands latched at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            col_r   <= '0;
            pt_r    <= '0;
            noise_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            col_r   <= col_nxt_s;
            if (accept_s) begin
                pt_r    <= plaintext;
                noise_r <= noise_select;
            end
        end
    end

    // Output registers, decoded from the upcoming state so they line up with it;
    // ct_* load on WAIT->OUT and hold until the handshake moves the FSM on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_ready_r <= 1'b1;
            pk_rd_en_r    <= 1'b0;
            pk_rd_addr_r  <= '0;
            ct_valid_r    <= 1'b0;
            ct_data_r     <= '0;
            ct_index_r    <= '0;
            ct_last_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            start_ready_r <= (state_nxt_s == ST_IDLE);
            pk_rd_en_r    <= (state_nxt_s == ST_FETCH);
            pk_rd_addr_r  <= (state_nxt_s == ST_FETCH) ? col_nxt_s : '0;
            ct_valid_r    <= (state_nxt_s == ST_OUT);
            busy_r        <= (state_nxt_s != ST_IDLE);
            if (state_r == ST_WAIT) begin
                ct_data_r  <= word_s;
                ct_index_r <= col_r;
                ct_last_r  <= (col_r == LAST_COL);
            end
        end
    end

    assign start_ready = start_ready_r;
    assign pk_rd_en    = pk_rd_en_r;
    assign pk_rd_addr  = pk_rd_addr_r;
    assign ct_valid    = ct_valid_r;
    assign ct_data     = ct_data_r;
    assign ct_index    = ct_index_r;
    assign ct_last     = ct_last_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_encrypt_ctrl.sv
// Scoreboard bench for encrypt_ctrl: requests push expected words computed
// from a plain-arithmetic LWE model; a monitor pops them on each handshake.
module tb_encrypt_ctrl;

    localparam int PW    = 6;
    localparam int D     = 1;
    localparam int CW    = 10;
    localparam int N     = 30;
    localparam int COL_W = 1;
    localparam int NCOL  = D + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_valid = 1'b0;
    logic              start_ready;
    logic [PW-1:0]     plaintext = '0;
    logic [N-1:0]      noise_select = '0;
    logic              pk_rd_en;
    logic [COL_W-1:0]  pk_rd_addr;
    logic [N*CW-1:0]   pk_rd_data = '0;
    logic              ct_valid;
    logic              ct_ready = 1'b0;
    logic [CW-1:0]     ct_data;
    logic [COL_W-1:0]  ct_index;
    logic              ct_last;
    logic              busy;

    encrypt_ctrl #(
        .PLAINTEXT_WIDTH  (PW),
        .DIMENSION        (D),
        .CIPHERTEXT_WIDTH (CW),
        .BIG_N            (N),
        .COL_W            (COL_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .plaintext    (plaintext),
        .noise_select (noise_select),
        .pk_rd_en     (pk_rd_en),
        .pk_rd_addr   (pk_rd_addr),
        .pk_rd_data   (pk_rd_data),
        .ct_valid     (ct_valid),
        .ct_ready     (ct_ready),
        .ct_data      (ct_data),
        .ct_index     (ct_index),
        .ct_last      (ct_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Public-key memory model: synchronous read, data one cycle after the strobe.
    int pk_mem [NCOL][N];
    always @(posedge clk) begin
        if (pk_rd_en) begin
            for (int i = 0; i < N; i++) pk_rd_data[i*CW +: CW] <= CW'(pk_mem[int'(pk_rd_addr)][i]);
        end
    end

    typedef struct {
        int data;
        int idx;
        bit last;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int errors  = 0;
    int accept_cyc = 0;
    int hs_cyc = 0;
    int last_hs_cyc = 0;
    bit rand_ready = 1'b0;
    bit ready_force = 1'b0;

    // Reference: sum of selected key entries plus pt*2^(CW-PW), all mod 2^CW.
    function automatic int model_word(int c, int pt, logic [N-1:0] ns);
        int s = 0;
        for (int i = 0; i < N; i++) if (ns[i]) s += pk_mem[c][i];
        if (c == D) s += pt * (2 ** (CW - PW));
        return s % (2 ** CW);
    endfunction

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fill_random();
        for (int c = 0; c < NCOL; c++)
            for (int i = 0; i < N; i++) pk_mem[c][i] = int'($urandom_range(0, 1023));
    endtask

    // Drive a request and wait (bounded) for it to be accepted; returns at
    // the negedge of the accept cycle with the expected words queued.
    task automatic issue(int pt, logic [N-1:0] ns);
        bit got = 1'b0;
        start_valid  = 1'b1;
        plaintext    = PW'(pt);
        noise_select = ns;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (start_ready && start_valid) begin
                got = 1'b1;
                accept_cyc = cyc;
                for (int c = 0; c < NCOL; c++) begin
                    exp_t e;
                    e.data = model_word(c, pt, ns);
                    e.idx  = c;
                    e.last = (c == D);
                    sb.push_back(e);
                end
            end
        end
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic drop_start();
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
        if (!ok) begin
            check("done_timeout", 0, 1);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_start_ready"}, int'(start_ready), 1);
        check({tag, "_ctrl"}, int'({pk_rd_en, ct_valid, busy, ct_last}), 0);
        check({tag, "_ct_data"}, int'(ct_data), 0);
        check({tag, "_addr_index"}, int'({pk_rd_addr, ct_index}), 0);
    endtask

    initial begin
        fork
            // Stimulus
            begin
                logic [N-1:0] nb;
                int pb;
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                check_reset_outputs("reset");
                rst = 1'b0;
                ready_force = 1'b1;
                @(posedge clk);
                #1;

                // Zero noise: only the plaintext term survives.
                fill_random();
                issue(5, '0);
                drop_start();
                wait_done();

                // All selected, wrapping sums.
                for (int i = 0; i < N; i++) begin
                    pk_mem[0][i] = 40;
                    pk_mem[1][i] = 1;
                end
                issue(63, '1);
                drop_start();
                wait_done();

                // Single selected entry at the top index.
                for (int i = 0; i < N; i++) begin
                    pk_mem[0][i] = (i == 29) ? 1023 : 7;
                    pk_mem[1][i] = (i == 29) ? 1023 : 7;
                end
                issue(0, N'(1) << 29);
                drop_start();
                wait_done();

                // Backpressure on word 0 for five cycles.
                fill_random();
                ready_force = 1'b0;
                @(posedge clk);
                #1;
                issue(int'($urandom_range(0, 63)), N'($urandom));
                drop_start();
                for (int k = 0; k < 20 && !ct_valid; k++) @(negedge clk);
                check("bp_valid_seen", int'(ct_valid), 1);
                repeat (5) @(posedge clk);
                ready_force = 1'b1;
                wait_done();

                // Reset during FETCH of column 0.
                issue(17, N'($urandom));
                @(posedge clk);
                #1;
                start_valid = 1'b0;
                check("fetch_en_before_rst", int'(pk_rd_en), 1);
                rst = 1'b1;
                #1;
                check_reset_outputs("rst_fetch");
                sb.delete();
                @(posedge clk);
                #1;
                rst = 1'b0;

                // Reset during WAIT of column 0.
                issue(33, N'($urandom));
                drop_start();
                @(posedge clk);
                #1;
                check("wait_busy_before_rst", int'({busy, pk_rd_en}), 2);
                rst = 1'b1;
                #1;
                check_reset_outputs("rst_wait");
                sb.delete();
                @(posedge clk);
                #1;
                rst = 1'b0;
                issue(5, '0);
                drop_start();
                wait_done();

                // start_valid held across two requests; operands change mid-op.
                fill_random();
                issue(int'($urandom_range(0, 63)), N'($urandom));
                @(posedge clk);
                #1;
                pb = int'($urandom_range(0, 63));
                nb = N'($urandom);
                plaintext = PW'(pb);
                noise_select = nb;
                issue(pb, nb);
                check("b2b_accept_cycle", accept_cyc, last_hs_cyc + 1);
                drop_start();
                wait_done();

                // Random operations with random backpressure.
                rand_ready = 1'b1;
                for (int n = 0; n < 20; n++) begin
                    fill_random();
                    issue(int'($urandom_range(0, 63)), N'($urandom));
                    drop_start();
                    wait_done();
                end
                rand_ready = 1'b0;
                repeat (3) @(posedge clk);
            end
            // Monitor / scoreboard
            begin
                bit prev_valid = 1'b0;
                bit prev_hs = 1'b0;
                int h_data = 0;
                int h_idx = 0;
                int h_last = 0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_valid = 1'b0;
                        prev_hs = 1'b0;
                    end else begin
                        if (pk_rd_en && sb.size() != 0)
                            check("rd_addr", int'(pk_rd_addr), sb[0].idx);
                        if (ct_valid) begin
                            check("ctrl_during_out", int'({pk_rd_en, start_ready, busy}), 1);
                            if (!prev_valid || prev_hs) begin
                                if (sb.size() == 0) check("unexpected_word", int'(ct_data), -1);
                                else check("valid_latency", cyc,
                                           (sb[0].idx == 0) ? accept_cyc + 3 : hs_cyc + 3);
                            end else begin
                                check("hold_data", int'(ct_data), h_data);
                                check("hold_index_last", int'({ct_index, ct_last}), (h_idx << 1) | h_last);
                            end
                            if (ct_ready && sb.size() != 0) begin
                                exp_t e;
                                e = sb.pop_front();
                                check("ct_data", int'(ct_data), e.data);
                                check("ct_index", int'(ct_index), e.idx);
                                check("ct_last", int'(ct_last), int'(e.last));
                                hs_cyc = cyc;
                                if (ct_last) last_hs_cyc = cyc;
                            end
                        end
                        prev_valid = ct_valid;
                        prev_hs = ct_valid && ct_ready;
                        h_data = int'(ct_data);
                        h_idx = int'(ct_index);
                        h_last = int'(ct_last);
                    end
                end
            end
            // Downstream ready driver
            begin
                forever begin
                    @(posedge clk);
                    #1;
                    ct_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
                end
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
